// File: rtl/debounce_event_scheduler_pkg.sv
// Shared types for the debounce event scheduler: event kinds, pending-slot
// indices and the within-button priority helpers.
package debounce_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2
    } evt_kind_t;

    localparam int N_PEND = 3;

    // Slot order doubles as service priority: lowest index is served first.
    localparam logic [1:0] PEND_PRESS   = 2'd0;
    localparam logic [1:0] PEND_LONG    = 2'd1;
    localparam logic [1:0] PEND_RELEASE = 2'd2;

    function automatic logic [1:0] pick_slot(input logic [N_PEND-1:0] pend);
        logic [1:0] slot;
        if (pend[PEND_PRESS]) begin
            slot = PEND_PRESS;
        end else if (pend[PEND_LONG]) begin
            slot = PEND_LONG;
        end else begin
            slot = PEND_RELEASE;
        end
        return slot;
    endfunction

    function automatic evt_kind_t slot_kind(input logic [1:0] slot);
        evt_kind_t kind;
        case (slot)
            PEND_PRESS: kind = EVT_PRESS;
            PEND_LONG:  kind = EVT_LONG;
            default:    kind = EVT_RELEASE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/debounce_event_scheduler_if.sv
// Valid/ready event port carrying the button index and event kind.
interface debounce_event_scheduler_if #(
    parameter int N_BUTTONS = 4
);
    import debounce_pkg::*;

    localparam int ID_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    evt_kind_t       evt_kind;

    modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);

endinterface

// File: rtl/debounce_event_scheduler_button_channel.sv
// One button: two-flop synchroniser, tick-driven debounce counter, hold
// counter for long presses, and single-cycle event request pulses.
module button_channel #(
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic button,
    output logic stable,
    output logic set_press,
    output logic set_release,
    output logic set_long
);

    localparam int DEB_W  = $clog2(STABLE_TICKS);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

    logic              sync1_r;
    logic              sync2_r;
    logic              stable_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              toggle_s;

    // Event requests are combinational so the top captures them on the same edge the level flips.
    always_comb begin
        toggle_s    = tick && (sync2_r != stable_r) && (deb_cnt_r == DEB_LAST);
        set_press   = toggle_s && !stable_r;
        set_release = toggle_s && stable_r;
        set_long    = tick && stable_r && (hold_cnt_r == HOLD_MAX - HOLD_W'(1));
    end

    // Synchroniser, debounce and hold counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            deb_cnt_r  <= '0;
            hold_cnt_r <= '0;
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
            if (tick) begin
                if (sync2_r == stable_r) begin
                    deb_cnt_r <= '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    deb_cnt_r <= '0;
                    stable_r  <= ~stable_r;
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end
            // Saturation keeps LONG to one event per press.
            if (!stable_r) begin
                hold_cnt_r <= '0;
            end else if (tick && (hold_cnt_r != HOLD_MAX)) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/debounce_event_scheduler.sv
// Debounces N_BUTTONS inputs on a shared tick and serialises their
// press/release/long events through a round-robin arbiter.
module debounce_event_scheduler
    import debounce_pkg::*;
#(
    parameter int N_BUTTONS    = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_BUTTONS-1:0]          buttons,
    output logic [N_BUTTONS-1:0]          stable,
    debounce_event_scheduler_if.master    evt,
    output logic                          evt_overflow,
    input  logic                          ovf_clear
);

    localparam int ID_W  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]                   presc_r;
    logic                               tick_s;
    logic [N_BUTTONS-1:0]               stable_s;
    logic [N_BUTTONS-1:0][N_PEND-1:0]   set_s;
    logic [N_BUTTONS-1:0][N_PEND-1:0]   clr_s;
    logic [N_BUTTONS-1:0][N_PEND-1:0]   pend_r;
    logic [N_BUTTONS-1:0][N_PEND-1:0]   pend_nxt_s;
    logic                               ovf_hit_s;
    logic                               ovf_r;
    logic [ID_W-1:0]                    ptr_r;
    logic [ID_W-1:0]                    sel_id_s;
    logic [1:0]                         sel_slot_s;
    logic                               load_s;
    logic                               valid_r;
    logic [ID_W-1:0]                    id_r;
    evt_kind_t                          kind_r;

    assign tick_s = (presc_r == PRE_W'(TICK_DIV - 1));

    // Shared sample-tick prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        button_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick_s),
            .button      (buttons[g]),
            .stable      (stable_s[g]),
            .set_press   (set_s[g][PEND_PRESS]),
            .set_release (set_s[g][PEND_RELEASE]),
            .set_long    (set_s[g][PEND_LONG])
        );
    end

    // Round-robin search: scanning downward in offset lets the nearest hit to the pointer win.
    always_comb begin
        logic [ID_W-1:0] cand_v;
        sel_id_s = '0;
        cand_v   = '0;
        for (int off = N_BUTTONS - 1; off >= 0; off--) begin
            cand_v   = ID_W'((int'(ptr_r) + off) % N_BUTTONS);
            sel_id_s = (|pend_r[cand_v]) ? cand_v : sel_id_s;
        end
        sel_slot_s = pick_slot(pend_r[sel_id_s]);
        load_s     = !valid_r && (|pend_r);
    end

    // Pending update: a set in the same cycle as a clear keeps the bit and is not an overflow.
    always_comb begin
        clr_s                         = '0;
        clr_s[sel_id_s][sel_slot_s]   = load_s;
        pend_nxt_s                    = (pend_r & ~clr_s) | set_s;
        ovf_hit_s                     = |(set_s & pend_r & ~clr_s);
    end

    // Pending bits and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            if (ovf_hit_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clear) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Output register and pointer; a load and a handshake never share a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            id_r    <= '0;
            kind_r  <= EVT_PRESS;
            ptr_r   <= '0;
        end else if (load_s) begin
            valid_r <= 1'b1;
            id_r    <= sel_id_s;
            kind_r  <= slot_kind(sel_slot_s);
        end else if (valid_r && evt.evt_ready) begin
            valid_r <= 1'b0;
            ptr_r   <= (id_r == ID_W'(N_BUTTONS - 1)) ? '0 : id_r + ID_W'(1);
        end
    end

    assign stable        = stable_s;
    assign evt_overflow  = ovf_r;
    assign evt.evt_valid = valid_r;
    assign evt.evt_id    = id_r;
    assign evt.evt_kind  = kind_r;

endmodule

// File: tb/tb_debounce_event_scheduler.sv
// Directed bench: phase table plus hand-timed sequences, with an accepted-event
// log compared against the expected event order at the end.
module tb_debounce_event_scheduler;
    import debounce_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic [3:0] stable;
    logic       evt_overflow;
    logic       ovf_clear;
    int         checks;
    int         failures;
    int         cyc;

    debounce_event_scheduler_if #(.N_BUTTONS(4)) ev ();

    debounce_event_scheduler #(
        .N_BUTTONS    (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .LONG_TICKS   (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons      (buttons),
        .stable       (stable),
        .evt          (ev),
        .evt_overflow (evt_overflow),
        .ovf_clear    (ovf_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        int         ncyc;
        logic [3:0] exp_stable;
        logic       exp_valid;
        logic       chk_idk;
        logic [1:0] exp_id;
        logic [1:0] exp_kind;
        logic       exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] kind;
    } ev_t;

    vec_t vecs [12];
    ev_t  got_q [$];
    ev_t  exp_q [$];

    always @(posedge clk) begin
        if (!reset && ev.evt_valid && ev.evt_ready) begin
            got_q.push_back({ev.evt_id, 2'(ev.evt_kind)});
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align();
        while (cyc % 4 != 0) step();
    endtask

    task automatic check_evt(input string name, input logic v, input logic [1:0] id, input logic [1:0] kind);
        check(name, 16'({ev.evt_valid, ev.evt_id, 2'(ev.evt_kind)}), 16'({v, id, kind}));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 16'({stable, ev.evt_valid, ev.evt_id, 2'(ev.evt_kind), evt_overflow}), 16'd0);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            buttons      = vecs[i].btn;
            ev.evt_ready = vecs[i].rdy;
            steps(vecs[i].ncyc);
            check($sformatf("vec%0d", i),
                  16'({stable, ev.evt_valid, evt_overflow,
                       vecs[i].chk_idk ? ev.evt_id : 2'b00,
                       vecs[i].chk_idk ? 2'(ev.evt_kind) : 2'b00}),
                  16'({vecs[i].exp_stable, vecs[i].exp_valid, vecs[i].exp_ovf,
                       vecs[i].exp_id, vecs[i].exp_kind}));
        end
    endtask

    initial begin
        int o0;
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        reset        = 1'b1;
        buttons      = 4'b0000;
        ovf_clear    = 1'b0;
        ev.evt_ready = 1'b1;

        // glitch rows start at a tick-aligned cycle straight after reset
        vecs[0]  = '{4'b0001, 1'b1,  8, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b1, 12, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        // backpressure then drain: 0 PRESS, 2 PRESS, 0 LONG, 2 LONG
        vecs[2]  = '{4'b0101, 1'b0, 14, 4'b0101, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        vecs[3]  = '{4'b0101, 1'b0, 40, 4'b0101, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
        vecs[4]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[5]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0};
        vecs[6]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
        vecs[8]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[9]  = '{4'b0101, 1'b1,  1, 4'b0101, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0};
        vecs[10] = '{4'b0101, 1'b1,  1, 4'b0101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[11] = '{4'b0101, 1'b1, 20, 4'b0101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

        exp_q.push_back({2'd1, 2'd0});
        exp_q.push_back({2'd1, 2'd2});
        exp_q.push_back({2'd1, 2'd1});
        exp_q.push_back({2'd0, 2'd0});
        exp_q.push_back({2'd2, 2'd0});
        exp_q.push_back({2'd0, 2'd2});
        exp_q.push_back({2'd2, 2'd2});
        exp_q.push_back({2'd2, 2'd1});
        exp_q.push_back({2'd3, 2'd0});
        exp_q.push_back({2'd3, 2'd1});
        exp_q.push_back({2'd0, 2'd1});
        exp_q.push_back({2'd3, 2'd1});

        steps(2);
        check_all_zero("reset_init");
        reset = 1'b0;
        cyc   = 0;

        run_vecs(0, 1);

        // clean press on button 1: ticks at +3,+7,+11 after the input change
        buttons = 4'b0010;
        steps(11);
        check("press_before", 16'(stable), 16'h0);
        step();
        check("press_stable", 16'(stable), 16'h2);
        check_evt("press_noevt_yet", 1'b0, 2'd0, 2'd0);
        step();
        check_evt("press_evt", 1'b1, 2'd1, 2'd0);
        step();
        check_evt("press_done", 1'b0, 2'd1, 2'd0);
        steps(18);
        check("long_early", 16'(ev.evt_valid), 16'h0);
        step();
        check_evt("long_evt", 1'b1, 2'd1, 2'd2);
        steps(3);
        buttons = 4'b0000;
        steps(11);
        check("release_before", 16'(stable), 16'h2);
        step();
        check("release_stable", 16'(stable), 16'h0);
        step();
        check_evt("release_evt", 1'b1, 2'd1, 2'd1);
        steps(40);

        // reset while an event is presented
        align();
        ev.evt_ready = 1'b0;
        buttons      = 4'b0100;
        steps(13);
        check_evt("pre_reset_evt", 1'b1, 2'd2, 2'd0);
        reset   = 1'b1;
        buttons = 4'b0000;
        step();
        check_all_zero("reset_mid");
        reset = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tick_c%0d", k), 16'(dut.tick_s), 16'(k == 3));
            if (k != 3) step();
        end

        align();
        run_vecs(2, 11);

        // overflow: button 2 RELEASE holds the port while button 3 presses twice
        align();
        o0 = cyc;
        ev.evt_ready = 1'b0;
        buttons      = 4'b0001;
        steps(13);
        check_evt("ovf_hold_evt", 1'b1, 2'd2, 2'd1);
        steps(3);
        buttons = 4'b1001;
        steps(16);
        check("ovf_press1", 16'(stable), 16'h9);
        buttons = 4'b0001;
        steps(16);
        check("ovf_release1", 16'(stable), 16'h1);
        buttons = 4'b1001;
        steps(11);
        check("ovf_not_yet", 16'(evt_overflow), 16'h0);
        step();
        check("ovf_set", 16'(evt_overflow), 16'h1);
        check_evt("ovf_evt_held", 1'b1, 2'd2, 2'd1);
        steps(4);
        check("ovf_cycle", 16'(cyc - o0), 16'd64);
        ev.evt_ready = 1'b1;
        buttons      = 4'b0000;
        steps(40);
        check("ovf_sticky", 16'(evt_overflow), 16'h1);
        check("ovf_all_released", 16'(stable), 16'h0);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_cleared", 16'(evt_overflow), 16'h0);
        step();
        check("ovf_stays_clear", 16'(evt_overflow), 16'h0);

        check("evt_count", 16'(got_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("evt_order%0d", i), 16'(got_q[i]), 16'(exp_q[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
